qei_step_counter_mc: RTL

- Multi-channel successor to the single-channel quadrature step counter with limit.
- NUM_CH independent quadrature (A/B) decoders, each with:
  - input synchroniser
  - 4x decode
  - signed position and unsigned step count
  - programmable step limit with sticky done flag
  - illegal-transition error flag
- All channels sit behind one byte-wide register bus (cs/rd/wr), with atomic multi-byte reads and a combined interrupt.

---
 rtl/qei_pkg.sv | 41 ++++
 rtl/qei_step_counter_mc_channel.sv | 149 ++++++++++++++
 rtl/qei_step_counter_mc.sv | 75 +++++++
 3 files changed

// File: rtl/qei_pkg.sv
// rtl/qei_pkg.sv - register map, flag bit positions and quadrature transition tables
package qei_pkg;

    localparam logic [2:0] OFS_POS_L   = 3'd0;
    localparam logic [2:0] OFS_POS_H   = 3'd1;
    localparam logic [2:0] OFS_STEPS_L = 3'd2;
    localparam logic [2:0] OFS_STEPS_H = 3'd3;
    localparam logic [2:0] OFS_LIM_L   = 3'd4;
    localparam logic [2:0] OFS_LIM_H   = 3'd5;
    localparam logic [2:0] OFS_STATUS  = 3'd6;
    localparam logic [2:0] OFS_CTRL    = 3'd7;

    localparam int ST_DONE = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_DIR  = 2;

    localparam int CT_EN      = 0;
    localparam int CT_CLR     = 1;
    localparam int CT_DONE_IE = 2;
    localparam int CT_ERR_IE  = 3;

    // {A,B} successor when turning clockwise: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] next_cw(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] next_ccw(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/qei_step_counter_mc_channel.sv
// rtl/qei_step_counter_mc_channel.sv - one quadrature channel (qei_channel); QEI_FILTER_EN adds a stability filter
module qei_channel
    import qei_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       sel,
    input  logic       rd,
    input  logic       wr,
    input  logic [2:0] ofs,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       irq
);

    logic [1:0]       sync1, sync2, cur, prev;
    logic [CNT_W-1:0] pos, steps, limit;
    logic             err, dir, en, done_ie, err_ie;
    logic [7:0]       sh_pos, sh_steps;
    logic [15:0]      pos_x, steps_x, limit_x;
    logic             wr_en, rd_en, clr_cnt, w1c, hit;
    logic             step_cw, step_ccw, bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {a, b};
            sync2 <= sync1;
        end
    end

`ifdef QEI_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN);
    logic [1:0]      filt;
    logic [FC_W-1:0] fcnt [2];

    // Each phase follows the synchroniser only once it has disagreed for FILT_LEN samples in a row
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                filt[i] <= 1'b0;
                fcnt[i] <= '0;
            end else if (sync2[i] == filt[i]) begin
                fcnt[i] <= '0;
            end else if (fcnt[i] == FC_W'(FILT_LEN - 1)) begin
                filt[i] <= sync2[i];
                fcnt[i] <= '0;
            end else begin
                fcnt[i] <= fcnt[i] + 1'b1;
            end
        end
    end
    assign cur = filt;
`else
    assign cur = sync2;
`endif

    assign wr_en   = sel && wr;
    assign rd_en   = sel && rd;
    assign clr_cnt = wr_en && (ofs == OFS_CTRL) && wdata[CT_CLR];
    assign w1c     = wr_en && (ofs == OFS_STATUS);
    assign pos_x   = 16'(pos);
    assign steps_x = 16'(steps);
    assign limit_x = 16'(limit);
    assign hit     = (limit != '0) && (steps >= limit);

    // prev keeps tracking while disabled, so re-enabling never counts a stale edge
    always_comb begin
        step_cw  = en && (cur == next_cw(prev));
        step_ccw = en && (cur == next_ccw(prev));
        bad      = en && (cur == ~prev);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= 2'b00;
            pos      <= '0;
            steps    <= '0;
            limit    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            dir      <= 1'b0;
            en       <= 1'b1;
            done_ie  <= 1'b0;
            err_ie   <= 1'b0;
            sh_pos   <= 8'h00;
            sh_steps <= 8'h00;
        end else begin
            prev <= cur;
            if (clr_cnt) begin
                pos   <= '0;
                steps <= '0;
            end else if (step_cw || step_ccw) begin
                pos <= step_cw ? pos + 1'b1 : pos - 1'b1;
                if (steps != '1)
                    steps <= steps + 1'b1;
            end
            if (step_cw || step_ccw)
                dir <= step_cw;

            // new events take precedence over a same-cycle clear
            done <= (done && !(w1c && wdata[ST_DONE])) || hit;
            err  <= (err && !(w1c && wdata[ST_ERR])) || bad;

            if (wr_en && (ofs == OFS_CTRL)) begin
                en      <= wdata[CT_EN];
                done_ie <= wdata[CT_DONE_IE];
                err_ie  <= wdata[CT_ERR_IE];
            end

            for (int i = 0; i < CNT_W; i++) begin
                if (wr_en && (ofs == OFS_LIM_L) && (i < 8))
                    limit[i] <= wdata[3'(i)];
                if (wr_en && (ofs == OFS_LIM_H) && (i >= 8))
                    limit[i] <= wdata[3'(i - 8)];
            end

            if (rd_en && (ofs == OFS_POS_L))
                sh_pos <= pos_x[15:8];
            if (rd_en && (ofs == OFS_STEPS_L))
                sh_steps <= steps_x[15:8];
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (ofs)
            OFS_POS_L:   rdata = pos_x[7:0];
            OFS_POS_H:   rdata = sh_pos;
            OFS_STEPS_L: rdata = steps_x[7:0];
            OFS_STEPS_H: rdata = sh_steps;
            OFS_LIM_L:   rdata = limit_x[7:0];
            OFS_LIM_H:   rdata = limit_x[15:8];
            OFS_STATUS:  rdata = {5'b0, dir, err, done};
            default:     rdata = {4'b0, err_ie, done_ie, 1'b0, en};
        endcase
    end

    assign irq = (done && done_ie) || (err && err_ie);

endmodule

// File: rtl/qei_step_counter_mc.sv
// rtl/qei_step_counter_mc.sv - multi-channel quadrature step counter; QEI_FILTER_EN enables input filters
module qei_step_counter_mc
    import qei_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          FILT_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       addr,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    input  logic [NUM_CH-1:0] A,
    input  logic [NUM_CH-1:0] B,
    output logic [NUM_CH-1:0] done,
    output logic              irq
);

    logic [15:0]       rel;
    logic [12:0]       ch_idx;
    logic              in_range;
    logic [NUM_CH-1:0] sel, ch_irq;
    logic [7:0]        ch_rdata [NUM_CH];
    logic [7:0]        rd_mux;

    assign rel      = addr - BASE_ADDR;
    assign ch_idx   = rel[15:3];
    assign in_range = (addr >= BASE_ADDR) && (ch_idx < 13'(NUM_CH));

    always_comb begin
        sel    = '0;
        rd_mux = 8'h00;
        for (int n = 0; n < NUM_CH; n++) begin
            sel[n] = cs && in_range && (ch_idx == 13'(n));
            if (sel[n])
                rd_mux = ch_rdata[n];
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        qei_channel #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .a     (A[n]),
            .b     (B[n]),
            .sel   (sel[n]),
            .rd    (rd),
            .wr    (wr),
            .ofs   (rel[2:0]),
            .wdata (data_in),
            .rdata (ch_rdata[n]),
            .done  (done[n]),
            .irq   (ch_irq[n])
        );
    end

    // rd_mux reflects pre-edge state, so a combined rd+wr returns the old value
    always_ff @(posedge clk) begin
        if (rst)
            data_out <= 8'h00;
        else if (cs && rd)
            data_out <= rd_mux;
    end

    assign irq = |ch_irq;

endmodule
